// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared types for the GPR writeback path: register index/data types and writeback source ids.
// The fallback widths describe a 32 x 64-bit register file when the core config does not provide them.
`ifndef RegIdWidth
`define RegIdWidth 5
`endif
`ifndef RegWidth
`define RegWidth 64
`endif
`ifndef RegCnt
`define RegCnt 32
`endif

package gpr_pkg;

    localparam int GPR_ADDR_WIDTH = `RegIdWidth;
    localparam int GPR_DATA_WIDTH = `RegWidth;
    localparam int GPR_REG_CNT    = `RegCnt;

    typedef logic [GPR_ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [GPR_DATA_WIDTH-1:0] reg_data_t;

    typedef enum logic {WB_EXU, WB_LSU} wb_src_e;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/gpr_wb_arbiter_scoreboard.sv
// Per-register busy scoreboard: marks destinations of issued instructions and clears them
// when their register-file write happens; raises issue_stall on RAW/WAW hazards.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int ADDR_WIDTH = `RegIdWidth,
    parameter int REG_CNT    = `RegCnt
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_wr,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] issue_rs1,
    input  logic [ADDR_WIDTH-1:0] issue_rs2,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_rd,
    output logic                  issue_stall
);

    logic [REG_CNT-1:0] busy;
    logic [REG_CNT-1:0] busy_next;
    logic               set_en;

    // Indices at or above REG_CNT read as not busy.
    function automatic logic busy_at(input logic [REG_CNT-1:0] vec,
                                     input logic [ADDR_WIDTH-1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < REG_CNT; i++) begin
            if (idx == ADDR_WIDTH'(i)) hit = vec[i];
        end
        return hit;
    endfunction

    // Only the registered busy vector is consulted; a clear landing this edge is not bypassed.
    always_comb begin
        issue_stall = issue_valid & (busy_at(busy, issue_rs1) | busy_at(busy, issue_rs2) |
                                     (issue_wr & busy_at(busy, issue_rd)));
    end

    assign set_en = issue_valid & ~issue_stall & issue_wr &
                    (issue_rd != ADDR_WIDTH'(REG_ZERO));

    // Clear is applied first so a coinciding set of the same register wins.
    always_comb begin
        busy_next = busy;
        for (int i = 0; i < REG_CNT; i++) begin
            if (clr_en && clr_rd == ADDR_WIDTH'(i)) busy_next[i] = 1'b0;
            if (set_en && issue_rd == ADDR_WIDTH'(i)) busy_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Round-robin writeback arbiter between EXU and LSU feeding the single GPR write port,
// with a registered write stage and the busy scoreboard that drives decode's stall.
module gpr_wb_arbiter
    import gpr_pkg::*;
#(
    parameter int ADDR_WIDTH = `RegIdWidth,
    parameter int DATA_WIDTH = `RegWidth,
    parameter int REG_CNT    = `RegCnt
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_wdata,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic                  issue_valid,
    input  logic                  issue_wr,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] issue_rs1,
    input  logic [ADDR_WIDTH-1:0] issue_rs2,
    output logic                  issue_stall,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    wb_src_e last_grant;
    logic    exu_fire;
    logic    lsu_fire;

    // Handshake: a transfer happens on a posedge with valid & ready; requesters hold valid and
    // payload until ready. ready is derived from both valids and last_grant only, never from
    // the requester's own ready. On contention the side that did not win last time goes first.
    assign exu_ready = exu_valid & (~lsu_valid | (last_grant == WB_LSU));
    assign lsu_ready = lsu_valid & (~exu_valid | (last_grant == WB_EXU));
    assign exu_fire  = exu_valid & exu_ready;
    assign lsu_fire  = lsu_valid & lsu_ready;

    // Writes to register 0 complete the handshake but never reach the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen     <= 1'b0;
            rf_rd      <= '0;
            rf_wdata   <= '0;
            last_grant <= WB_LSU;
        end else begin
            rf_wen <= 1'b0;
            if (exu_fire) begin
                last_grant <= WB_EXU;
                rf_wen     <= (exu_rd != ADDR_WIDTH'(REG_ZERO));
                rf_rd      <= exu_rd;
                rf_wdata   <= exu_wdata;
            end else if (lsu_fire) begin
                last_grant <= WB_LSU;
                rf_wen     <= (lsu_rd != ADDR_WIDTH'(REG_ZERO));
                rf_rd      <= lsu_rd;
                rf_wdata   <= lsu_wdata;
            end
        end
    end

    gpr_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_CNT    (REG_CNT)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_wr    (issue_wr),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .clr_en      (rf_wen),
        .clr_rd      (rf_rd),
        .issue_stall (issue_stall)
    );

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: a vector table for arbitration/write-stage behaviour,
// then hand-written sequences for RAW, WAW, simultaneous set/clear and asynchronous reset.
module tb_gpr_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, exu_ready;
    logic [4:0]  exu_rd;
    logic [63:0] exu_wdata;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_wdata;
    logic        issue_valid, issue_wr;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        issue_stall;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [63:0] rf_wdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        ev;
        logic [4:0]  erd;
        logic [63:0] ewd;
        logic        lv;
        logic [4:0]  lrd;
        logic [63:0] lwd;
        logic        exp_er;
        logic        exp_lr;
        logic        exp_wen;
        logic        chk_pl;
        logic [4:0]  exp_rd;
        logic [63:0] exp_wd;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    gpr_wb_arbiter #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (64),
        .REG_CNT    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .exu_valid   (exu_valid),
        .exu_ready   (exu_ready),
        .exu_rd      (exu_rd),
        .exu_wdata   (exu_wdata),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_wdata   (lsu_wdata),
        .issue_valid (issue_valid),
        .issue_wr    (issue_wr),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_stall (issue_stall),
        .rf_wen      (rf_wen),
        .rf_rd       (rf_rd),
        .rf_wdata    (rf_wdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        exu_valid = 1'b0; exu_rd = '0; exu_wdata = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_wdata = '0;
        issue_valid = 1'b0; issue_wr = 1'b0;
        issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
    endtask

    task automatic do_issue(input logic [4:0] rd);
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = rd;
        issue_rs1 = '0; issue_rs2 = '0;
        next_cycle();
        issue_valid = 1'b0; issue_wr = 1'b0; issue_rd = '0;
    endtask

    initial begin
        //           ev    erd    ewd        lv    lrd    lwd       er    lr    wen   pl    rd     wd
        vecs[0]  = '{1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 64'h0,    1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 64'hDEAD};
        vecs[1]  = '{1'b0, 5'd0, 64'h0,    1'b1, 5'd6, 64'h66,   1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 64'h66};
        vecs[2]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 64'h66};
        vecs[3]  = '{1'b1, 5'd1, 64'h11,   1'b1, 5'd2, 64'h22,   1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 64'h11};
        vecs[4]  = '{1'b1, 5'd1, 64'h11,   1'b1, 5'd2, 64'h22,   1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 64'h22};
        vecs[5]  = '{1'b1, 5'd1, 64'h11,   1'b1, 5'd2, 64'h22,   1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 64'h11};
        vecs[6]  = '{1'b1, 5'd1, 64'h11,   1'b1, 5'd2, 64'h22,   1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 64'h22};
        vecs[7]  = '{1'b0, 5'd0, 64'h0,    1'b1, 5'd0, 64'h77,   1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0};
        vecs[8]  = '{1'b1, 5'd0, 64'h88,   1'b0, 5'd0, 64'h0,    1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0};
        vecs[9]  = '{1'b1, 5'd3, 64'h33,   1'b1, 5'd4, 64'h44,   1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 64'h44};
        vecs[10] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 64'h44};

        // Clock/reset
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_rf_wen", 64'(rf_wen), 64'h0);
        chk("reset_rf_rd", 64'(rf_rd), 64'h0);
        chk("reset_rf_wdata", rf_wdata, 64'h0);
        chk("reset_stall", 64'(issue_stall), 64'h0);
        chk("reset_busy", 64'(dut.u_sb.busy), 64'h0);
        chk("reset_exu_ready_idle", 64'(exu_ready), 64'h0);

        // Vector table: arbitration and write stage
        for (int i = 0; i < 11; i++) begin
            exu_valid = vecs[i].ev; exu_rd = vecs[i].erd; exu_wdata = vecs[i].ewd;
            lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_wdata = vecs[i].lwd;
            #1;
            chk($sformatf("v%0d_exu_ready", i), 64'(exu_ready), 64'(vecs[i].exp_er));
            chk($sformatf("v%0d_lsu_ready", i), 64'(lsu_ready), 64'(vecs[i].exp_lr));
            next_cycle();
            chk($sformatf("v%0d_rf_wen", i), 64'(rf_wen), 64'(vecs[i].exp_wen));
            if (vecs[i].chk_pl) begin
                chk($sformatf("v%0d_rf_rd", i), 64'(rf_rd), 64'(vecs[i].exp_rd));
                chk($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].exp_wd);
            end
        end
        drive_idle();
        chk("zero_reg_busy_unchanged", 64'(dut.u_sb.busy), 64'h0);

        // RAW hazard on x7
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd7;
        #1 chk("raw_issue_no_stall", 64'(issue_stall), 64'h0);
        next_cycle();
        issue_wr = 1'b0; issue_rd = '0; issue_rs1 = 5'd7;
        #1 chk("raw_stall_set", 64'(issue_stall), 64'h1);
        next_cycle();
        chk("raw_stall_hold", 64'(issue_stall), 64'h1);
        exu_valid = 1'b1; exu_rd = 5'd7; exu_wdata = 64'h77;
        #1 chk("raw_exu_ready", 64'(exu_ready), 64'h1);
        next_cycle();
        exu_valid = 1'b0;
        chk("raw_wen", 64'(rf_wen), 64'h1);
        chk("raw_wen_rd", 64'(rf_rd), 64'h7);
        chk("raw_stall_during_wen", 64'(issue_stall), 64'h1);
        next_cycle();
        chk("raw_stall_released", 64'(issue_stall), 64'h0);
        chk("raw_wen_drop", 64'(rf_wen), 64'h0);
        drive_idle();

        // WAW stall, then set x9 and clear x4 on the same edge
        do_issue(5'd3);
        do_issue(5'd4);
        chk("waw_busy_3_4", 64'(dut.u_sb.busy), 64'h18);
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd3;
        exu_valid = 1'b1; exu_rd = 5'd4; exu_wdata = 64'h44;
        #1 chk("waw_stall", 64'(issue_stall), 64'h1);
        next_cycle();
        exu_valid = 1'b0;
        chk("waw_no_set_while_stalled", 64'(dut.u_sb.busy), 64'h18);
        chk("waw_wen_x4", 64'(rf_wen), 64'h1);
        issue_rd = 5'd9;
        #1 chk("set9_no_stall", 64'(issue_stall), 64'h0);
        next_cycle();
        chk("set9_clr4_same_edge", 64'(dut.u_sb.busy), 64'h208);
        drive_idle();

        // Asynchronous reset in the middle of an rf_wen cycle
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        do_issue(5'd4);
        do_issue(5'd7);
        issue_valid = 1'b1; issue_rs1 = 5'd4;
        exu_valid = 1'b1; exu_rd = 5'd5; exu_wdata = 64'h55;
        next_cycle();
        exu_valid = 1'b0;
        chk("pre_rst_wen", 64'(rf_wen), 64'h1);
        chk("pre_rst_busy", 64'(dut.u_sb.busy), 64'h90);
        chk("pre_rst_stall", 64'(issue_stall), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_wen", 64'(rf_wen), 64'h0);
        chk("async_rst_busy", 64'(dut.u_sb.busy), 64'h0);
        chk("async_rst_stall", 64'(issue_stall), 64'h0);
        next_cycle();
        rst = 1'b0;
        drive_idle();
        #1 chk("post_rst_wen_a", 64'(rf_wen), 64'h0);
        next_cycle();
        chk("post_rst_wen_b", 64'(rf_wen), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
